// File: rtl/sort_register_engine.sv
// Five-word load / bubble-sort / display-scan engine feeding the result
// multiplexor. R0..R4 hold the words in load order, RP0..RP4 a working copy
// that is sorted ascending. The scan phase then steps the select through
// 1..10 so that all ten registers reach the display in turn.
//
//  state | meaning
//  LOAD  | accepting words into R[idx]/RP[idx], sDataReady high
//  SORT  | one bubble-sort compare per clock, ten compares in total
//  SCAN  | result valid, sSelMux cycles 1..10, SCAN_TICKS clocks per value
module sort_register_engine #(
    parameter int DATAWIDTH  = 9,
    parameter int SELECTION  = 4,
    parameter int SCAN_TICKS = 25000000,
    parameter int SCAN_CNT_W = 25
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InHigh,
    input  logic [DATAWIDTH-1:0] sDataIn,
    input  logic                 sDataValid,
    output logic                 sDataReady,
    input  logic                 sClear,
    output logic                 sBusy,
    output logic                 sDone,
    output logic [3:0]           sSwapCount,
    output logic [DATAWIDTH-1:0] sR0,
    output logic [DATAWIDTH-1:0] sR1,
    output logic [DATAWIDTH-1:0] sR2,
    output logic [DATAWIDTH-1:0] sR3,
    output logic [DATAWIDTH-1:0] sR4,
    output logic [DATAWIDTH-1:0] sRP0,
    output logic [DATAWIDTH-1:0] sRP1,
    output logic [DATAWIDTH-1:0] sRP2,
    output logic [DATAWIDTH-1:0] sRP3,
    output logic [DATAWIDTH-1:0] sRP4,
    output logic [SELECTION-1:0] sSelMux
);

    typedef enum logic [1:0] {LOAD, SORT, SCAN} state_t;

    state_t                 state_q;
    logic [2:0]             idx_q;
    logic [1:0]             pass_q;
    logic [2:0]             j_q;
    logic [DATAWIDTH-1:0]   r_q  [5];
    logic [DATAWIDTH-1:0]   rp_q [5];
    logic [3:0]             swap_q;
    logic [SELECTION-1:0]   sel_q;
    logic                   busy_q;
    logic                   done_q;
    logic [SCAN_CNT_W-1:0]  cnt_q;

    logic [DATAWIDTH-1:0]   lo_d;
    logic [DATAWIDTH-1:0]   hi_d;
    logic                   swap_d;
    logic                   last_j_d;
    logic                   last_cmp_d;
    logic                   scan_tc_d;
    logic [SELECTION-1:0]   sel_d;

    // Current compare pair, end-of-pass / end-of-sort detection, scan step.
    always_comb begin
        lo_d       = rp_q[j_q];
        hi_d       = rp_q[j_q + 3'd1];
        swap_d     = lo_d > hi_d;
        last_j_d   = (j_q == (3'd3 - {1'b0, pass_q}));
        last_cmp_d = (pass_q == 2'd3) && last_j_d;
        scan_tc_d  = (cnt_q == SCAN_CNT_W'(SCAN_TICKS - 1));
        sel_d      = (sel_q == SELECTION'(10)) ? SELECTION'(1) : sel_q + SELECTION'(1);
    end

    // Sequencer: load, sort and scan with all outputs registered.
    always_ff @(posedge CLOCK_50) begin
        if (RESET_InHigh || sClear) begin
            // Clear behaves exactly like reset; a word offered on the same
            // edge is deliberately dropped.
            state_q <= LOAD;
            idx_q   <= '0;
            pass_q  <= '0;
            j_q     <= '0;
            swap_q  <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < 5; i++) begin
                r_q[i]  <= '0;
                rp_q[i] <= '0;
            end
        end else begin
            case (state_q)
                LOAD: begin
                    if (sDataValid) begin
                        r_q[idx_q]  <= sDataIn;
                        rp_q[idx_q] <= sDataIn;
                        if (idx_q == 3'd4) begin
                            state_q <= SORT;
                            idx_q   <= '0;
                            pass_q  <= '0;
                            j_q     <= '0;
                            swap_q  <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                SORT: begin
                    // Strict compare keeps equal words in place (stable sort).
                    if (swap_d) begin
                        rp_q[j_q]        <= hi_d;
                        rp_q[j_q + 3'd1] <= lo_d;
                        swap_q           <= swap_q + 4'd1;
                    end
                    if (last_cmp_d) begin
                        state_q <= SCAN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sel_q   <= SELECTION'(1);
                        cnt_q   <= '0;
                    end else if (last_j_d) begin
                        pass_q <= pass_q + 2'd1;
                        j_q    <= '0;
                    end else begin
                        j_q <= j_q + 3'd1;
                    end
                end
                SCAN: begin
                    if (scan_tc_d) begin
                        cnt_q <= '0;
                        sel_q <= sel_d;
                    end else begin
                        cnt_q <= cnt_q + SCAN_CNT_W'(1);
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign sDataReady = (state_q == LOAD);
    assign sBusy      = busy_q;
    assign sDone      = done_q;
    assign sSwapCount = swap_q;
    assign sSelMux    = sel_q;
    assign sR0        = r_q[0];
    assign sR1        = r_q[1];
    assign sR2        = r_q[2];
    assign sR3        = r_q[3];
    assign sR4        = r_q[4];
    assign sRP0       = rp_q[0];
    assign sRP1       = rp_q[1];
    assign sRP2       = rp_q[2];
    assign sRP3       = rp_q[3];
    assign sRP4       = rp_q[4];

endmodule
